// File: rtl/param_counter_pkg.sv
// Shared constants for the free-running parameterised counter.
// The terminal-value helper gives the all-ones pattern for any legal width.
package param_counter_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int CNT_W_MIN     = 1;
    localparam int CNT_W_LIMIT   = 32;

    // All-ones value for a counter of width w, right-aligned in 32 bits
    function automatic logic [31:0] cnt_max(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/param_counter.sv
// Free-running CNT_W-bit up-counter with a one-cycle terminal-count flag.
// Overflow is registered alongside count so it never depends on an input path.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    generate
        if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_LIMIT)) begin : g_bad_width
            $error("param_counter: CNT_W must be in 1..32");
        end
    endgenerate

    localparam logic [31:0]      CNT_MAX_W = cnt_max(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             overflow_nxt_s;

    // Next value is computed at exactly CNT_W bits so the wrap is implicit
    always_comb begin
        count_nxt_s    = count_r + CNT_ONE;
        overflow_nxt_s = (count_nxt_s == CNT_MAX);
    end

    // Count and terminal flag registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench: several widths share one clock and reset, and every
// output is compared against (edges since release) mod 2^W.
module tb_param_counter;

    logic        clk;
    logic        rst_n;
    logic [0:0]  c1;
    logic [1:0]  c2;
    logic [2:0]  c3;
    logic [7:0]  c8;
    logic [15:0] c16;
    logic        o1, o2, o3, o8, o16;

    int     tests = 0;
    int     fails = 0;
    longint n     = 0;
    bit     in_rst = 1'b1;

    param_counter #(.CNT_W(1))  u_w1  (.clk(clk), .rst_n(rst_n), .count(c1),  .overflow(o1));
    param_counter #(.CNT_W(2))  u_w2  (.clk(clk), .rst_n(rst_n), .count(c2),  .overflow(o2));
    param_counter #(.CNT_W(3))  u_w3  (.clk(clk), .rst_n(rst_n), .count(c3),  .overflow(o3));
    param_counter #(.CNT_W(8))  u_w8  (.clk(clk), .rst_n(rst_n), .count(c8),  .overflow(o8));
    param_counter #(.CNT_W(16)) u_w16 (.clk(clk), .rst_n(rst_n), .count(c16), .overflow(o16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edges since release %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int w);
        longint period;
        period = longint'(1) << w;
        if (in_rst) return 32'd0;
        return 32'(n % period);
    endfunction

    function automatic logic [31:0] exp_ov(input int w);
        longint period;
        period = longint'(1) << w;
        if (in_rst) return 32'd0;
        return ((n % period) == period - 1) ? 32'd1 : 32'd0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, " cnt1"},  32'(c1),  exp_cnt(1));
        check({tag, " ov1"},   32'(o1),  exp_ov(1));
        check({tag, " cnt2"},  32'(c2),  exp_cnt(2));
        check({tag, " ov2"},   32'(o2),  exp_ov(2));
        check({tag, " cnt3"},  32'(c3),  exp_cnt(3));
        check({tag, " ov3"},   32'(o3),  exp_ov(3));
        check({tag, " cnt8"},  32'(c8),  exp_cnt(8));
        check({tag, " ov8"},   32'(o8),  exp_ov(8));
        check({tag, " cnt16"}, 32'(c16), exp_cnt(16));
        check({tag, " ov16"},  32'(o16), exp_ov(16));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!in_rst) n++;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        n      = 0;
    endtask

    // Assert reset asynchronously a random time after a rising edge and
    // check that everything clears before the next edge arrives.
    task automatic async_reset(input string tag);
        int dly;
        @(posedge clk);
        if (!in_rst) n++;
        dly = $urandom_range(1, 7);
        #(dly);
        rst_n  = 1'b0;
        in_rst = 1'b1;
        #1;
        check_all(tag);
    endtask

    int ov16_high = 0;

    initial begin
        int pre;
        int extra;

        rst_n = 1'b0;
        #100;
        check_all("reset_hold");
        @(posedge clk);
        #1;
        check_all("reset_across_edge");

        release_rst();
        pre = $urandom_range(10, 200);
        for (int i = 0; i < pre; i++) step("pre_run");
        async_reset("async_clear");
        step("held_reset");

        release_rst();
        step("first_edge");
        check("first_edge_is_one", 32'(c16), 32'd1);
        while (n < 65535) begin
            step("full_run");
            if (o16) ov16_high++;
        end
        check("full_max16",   32'(c16), 32'h0000_FFFF);
        check("full_ov16",    32'(o16), 32'd1);
        check("ov16_first_at_max", 32'(ov16_high), 32'd1);

        step("wrap");
        check("wrap_cnt16", 32'(c16), 32'd0);
        check("wrap_ov16",  32'(o16), 32'd0);
        for (int i = 0; i < 10; i++) step("post_wrap");
        check("post_wrap16", 32'(c16), 32'h0000_000A);
        check("post_wrap1",  32'(c1),  32'd0);
        check("post_wrap2",  32'(c2),  32'd2);
        check("post_wrap3",  32'(c3),  32'd2);

        // Run to a point where the 8-bit instance sits at its terminal value,
        // then reset while its overflow is high.
        extra = $urandom_range(0, 2);
        while ((n % 256) != 254) step("to_max8");
        for (int i = 0; i < extra * 256; i++) step("to_max8_extra");
        async_reset("mid_reset_at_ov8");
        check("mid_reset_ov8", 32'(o8), 32'd0);

        release_rst();
        step("restart");
        check("restart_cnt8", 32'(c8), 32'd1);
        while (n < 255) step("restart_run");
        check("restart_max8", 32'(c8), 32'h0000_00FF);
        check("restart_ov8",  32'(o8), 32'd1);
        step("restart_wrap");
        check("restart_wrap8", 32'(c8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
